// File: rtl/axi4_to_ahb_bridge_pkg.sv
// Shared types and constants for the single-outstanding AXI4 to AHB-Lite bridge.
package axi4_to_ahb_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    RESP = 2'd3
  } axi2ahb_state_t;

  localparam logic [1:0] RESP_OKAY     = 2'b00;
  localparam logic [1:0] RESP_SLVERR   = 2'b10;
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  // Only the low three address bits matter for naturally aligned 1..8 byte accesses.
  function automatic logic is_misaligned(input logic [2:0] addr_lo, input logic [1:0] size);
    logic mis;
    case (size)
      2'd1:    mis = addr_lo[0];
      2'd2:    mis = |addr_lo[1:0];
      2'd3:    mis = |addr_lo[2:0];
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/axi4_to_ahb_bridge_if.sv
// AXI4 slave port and AHB-Lite master port of the bridge as one bundle.
// Modports are named from the AXI side: slave = the bridge, master = the core/fabric environment.
interface axi4_to_ahb_bridge_if #(parameter int TAG = 1);

  logic           axi_awvalid, axi_awready;
  logic [TAG-1:0] axi_awid;
  logic [31:0]    axi_awaddr;
  logic [2:0]     axi_awsize, axi_awprot;
  logic [7:0]     axi_awlen;
  logic [1:0]     axi_awburst;

  logic           axi_wvalid, axi_wready, axi_wlast;
  logic [63:0]    axi_wdata;
  logic [7:0]     axi_wstrb;

  logic           axi_bvalid, axi_bready;
  logic [1:0]     axi_bresp;
  logic [TAG-1:0] axi_bid;

  logic           axi_arvalid, axi_arready;
  logic [TAG-1:0] axi_arid;
  logic [31:0]    axi_araddr;
  logic [2:0]     axi_arsize, axi_arprot;
  logic [7:0]     axi_arlen;
  logic [1:0]     axi_arburst;

  logic           axi_rvalid, axi_rready, axi_rlast;
  logic [TAG-1:0] axi_rid;
  logic [63:0]    axi_rdata;
  logic [1:0]     axi_rresp;

  logic [31:0]    ahb_haddr;
  logic [2:0]     ahb_hburst, ahb_hsize;
  logic           ahb_hmastlock, ahb_hwrite;
  logic [3:0]     ahb_hprot;
  logic [1:0]     ahb_htrans;
  logic [63:0]    ahb_hwdata, ahb_hrdata;
  logic           ahb_hready, ahb_hresp;

  modport slave (
    input  axi_awvalid, axi_awid, axi_awaddr, axi_awsize, axi_awprot, axi_awlen, axi_awburst,
    output axi_awready,
    input  axi_wvalid, axi_wdata, axi_wstrb, axi_wlast,
    output axi_wready,
    output axi_bvalid, axi_bresp, axi_bid,
    input  axi_bready,
    input  axi_arvalid, axi_arid, axi_araddr, axi_arsize, axi_arprot, axi_arlen, axi_arburst,
    output axi_arready,
    output axi_rvalid, axi_rid, axi_rdata, axi_rresp, axi_rlast,
    input  axi_rready,
    output ahb_haddr, ahb_hburst, ahb_hmastlock, ahb_hprot, ahb_hsize, ahb_htrans,
    output ahb_hwrite, ahb_hwdata,
    input  ahb_hrdata, ahb_hready, ahb_hresp
  );

  modport master (
    output axi_awvalid, axi_awid, axi_awaddr, axi_awsize, axi_awprot, axi_awlen, axi_awburst,
    input  axi_awready,
    output axi_wvalid, axi_wdata, axi_wstrb, axi_wlast,
    input  axi_wready,
    input  axi_bvalid, axi_bresp, axi_bid,
    output axi_bready,
    output axi_arvalid, axi_arid, axi_araddr, axi_arsize, axi_arprot, axi_arlen, axi_arburst,
    input  axi_arready,
    input  axi_rvalid, axi_rid, axi_rdata, axi_rresp, axi_rlast,
    output axi_rready,
    input  ahb_haddr, ahb_hburst, ahb_hmastlock, ahb_hprot, ahb_hsize, ahb_htrans,
    input  ahb_hwrite, ahb_hwdata,
    output ahb_hrdata, ahb_hready, ahb_hresp
  );

endinterface

// File: rtl/axi4_to_ahb_bridge_arb.sv
// Two-requester round-robin arbiter (write vs read) remembering the last winner.
module axi4_to_ahb_bridge_arb (
  input  logic clk,
  input  logic rst,
  input  logic wr_req,
  input  logic rd_req,
  input  logic update,
  output logic grant_wr,
  output logic grant_rd
);

  logic last_rd_q;

  // Under contention the side that did not win last time gets the grant.
  assign grant_wr = wr_req & (~rd_req | last_rd_q);
  assign grant_rd = rd_req & ~grant_wr;

  always_ff @(posedge clk) begin
    if (rst) begin
      last_rd_q <= 1'b1;
    end else if (update) begin
      last_rd_q <= grant_rd;
    end
  end

endmodule

// File: rtl/axi4_to_ahb_bridge.sv
// Single-outstanding AXI4 slave to AHB-Lite master bridge, 64-bit data, single-beat only.
// Define AXI4_TO_AHB_ALIGN_CHK_EN to answer misaligned commands with SLVERR without touching AHB.
module axi4_to_ahb_bridge #(
  parameter int TAG = 1
) (
  input logic              clk,
  input logic              rst,
  axi4_to_ahb_bridge_if.slave bus
);
  import axi4_to_ahb_bridge_pkg::*;

  axi2ahb_state_t state_q, state_d;

  logic           wr_req, rd_req, grant_wr, grant_rd, accept;
  logic [31:0]    cmd_addr;
  logic [1:0]     cmd_size;
  logic           cmd_misaligned;

  logic [TAG-1:0] id_q;
  logic [31:0]    addr_q;
  logic [1:0]     size_q;
  logic           write_q;
  logic           prot_instr_q;
  logic [63:0]    wdata_q;
  logic [63:0]    rdata_q;
  logic           err_q;
  logic           resp_done;

  assign wr_req = bus.axi_awvalid & bus.axi_wvalid;
  assign rd_req = bus.axi_arvalid;

  axi4_to_ahb_bridge_arb u_arb (
    .clk      (clk),
    .rst      (rst),
    .wr_req   (wr_req),
    .rd_req   (rd_req),
    .update   (accept),
    .grant_wr (grant_wr),
    .grant_rd (grant_rd)
  );

  assign accept   = (state_q == IDLE) & (grant_wr | grant_rd);
  assign cmd_addr = grant_wr ? bus.axi_awaddr : bus.axi_araddr;
  assign cmd_size = grant_wr ? bus.axi_awsize[1:0] : bus.axi_arsize[1:0];

`ifdef AXI4_TO_AHB_ALIGN_CHK_EN
  assign cmd_misaligned = is_misaligned(cmd_addr[2:0], cmd_size);
`else
  assign cmd_misaligned = 1'b0;
`endif

  assign resp_done = write_q ? bus.axi_bready : bus.axi_rready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = cmd_misaligned ? RESP : ADDR;
      ADDR:    if (bus.ahb_hready) state_d = DATA;
      DATA:    if (bus.ahb_hready) state_d = RESP;
      RESP:    if (resp_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.axi_awready = 1'b0;
    bus.axi_wready  = 1'b0;
    bus.axi_arready = 1'b0;
    bus.axi_bvalid  = 1'b0;
    bus.axi_rvalid  = 1'b0;
    bus.axi_rlast   = 1'b0;
    bus.ahb_htrans  = HTRANS_IDLE;
    case (state_q)
      IDLE: begin
        bus.axi_awready = grant_wr;
        bus.axi_wready  = grant_wr;
        bus.axi_arready = grant_rd;
      end
      ADDR: bus.ahb_htrans = HTRANS_NONSEQ;
      RESP: begin
        bus.axi_bvalid = write_q;
        bus.axi_rvalid = ~write_q;
        bus.axi_rlast  = ~write_q;
      end
      default: ;
    endcase
  end

  // One-entry command buffer; rdata is cleared at acceptance so a rejected read returns zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      id_q         <= '0;
      addr_q       <= '0;
      size_q       <= '0;
      write_q      <= 1'b0;
      prot_instr_q <= 1'b0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
    end else if (accept) begin
      id_q         <= grant_wr ? bus.axi_awid : bus.axi_arid;
      addr_q       <= cmd_addr;
      size_q       <= cmd_size;
      write_q      <= grant_wr;
      prot_instr_q <= grant_wr ? bus.axi_awprot[2] : bus.axi_arprot[2];
      wdata_q      <= bus.axi_wdata;
      rdata_q      <= '0;
      err_q        <= cmd_misaligned;
    end else if ((state_q == DATA) && bus.ahb_hready) begin
      err_q <= bus.ahb_hresp;
      if (!write_q) begin
        rdata_q <= bus.ahb_hrdata;
      end
    end
  end

  assign bus.ahb_haddr     = addr_q;
  assign bus.ahb_hsize     = {1'b0, size_q};
  assign bus.ahb_hwrite    = write_q;
  assign bus.ahb_hprot     = {2'b00, 1'b1, ~prot_instr_q};
  assign bus.ahb_hwdata    = wdata_q;
  assign bus.ahb_hburst    = 3'b000;
  assign bus.ahb_hmastlock = 1'b0;

  assign bus.axi_bresp = err_q ? RESP_SLVERR : RESP_OKAY;
  assign bus.axi_rresp = err_q ? RESP_SLVERR : RESP_OKAY;
  assign bus.axi_bid   = id_q;
  assign bus.axi_rid   = id_q;
  assign bus.axi_rdata = rdata_q;

  logic unused_bus;
  assign unused_bus = ^{bus.axi_awlen, bus.axi_awburst, bus.axi_awsize[2], bus.axi_awprot[1:0],
                        bus.axi_arlen, bus.axi_arburst, bus.axi_arsize[2], bus.axi_arprot[1:0],
                        bus.axi_wstrb, bus.axi_wlast};

endmodule

// File: tb/tb_axi4_to_ahb_bridge.sv
// Directed self-checking bench for axi4_to_ahb_bridge; honours AXI4_TO_AHB_ALIGN_CHK_EN.
module tb_axi4_to_ahb_bridge;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  axi4_to_ahb_bridge_if #(.TAG(1)) bus ();

  axi4_to_ahb_bridge #(.TAG(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input bit is_write, input bit valid, input logic [31:0] addr,
                               input logic [2:0] size, input logic id, input logic [63:0] data);
    if (is_write) begin
      bus.axi_awvalid = valid;
      bus.axi_wvalid  = valid;
      bus.axi_awaddr  = addr;
      bus.axi_awsize  = size;
      bus.axi_awid    = id;
      bus.axi_wdata   = data;
    end else begin
      bus.axi_arvalid = valid;
      bus.axi_araddr  = addr;
      bus.axi_arsize  = size;
      bus.axi_arid    = id;
    end
  endtask

  task automatic clearAll();
    applyStimulus(1'b1, 1'b0, 32'h0, 3'd0, 1'b0, 64'h0);
    applyStimulus(1'b0, 1'b0, 32'h0, 3'd0, 1'b0, 64'h0);
    bus.axi_awprot  = 3'd0;
    bus.axi_arprot  = 3'd0;
    bus.axi_awlen   = 8'd0;
    bus.axi_arlen   = 8'd0;
    bus.axi_awburst = 2'd1;
    bus.axi_arburst = 2'd1;
    bus.axi_wstrb   = 8'hFF;
    bus.axi_wlast   = 1'b1;
    bus.axi_bready  = 1'b0;
    bus.axi_rready  = 1'b0;
    bus.ahb_hready  = 1'b1;
    bus.ahb_hresp   = 1'b0;
    bus.ahb_hrdata  = 64'h0;
  endtask

  initial begin
    logic [7:0] order [4];
    string      exp_order;
    int         n_acc;
    int         hold_cnt;

    clearAll();
    rst = 1'b1;
    repeat (3) tick();
    mid();
    checkOutput("rst_htrans", bus.ahb_htrans, 2'b00);
    checkOutput("rst_haddr", bus.ahb_haddr, 32'h0);
    checkOutput("rst_hsize", bus.ahb_hsize, 3'd0);
    checkOutput("rst_hwrite", bus.ahb_hwrite, 1'b0);
    checkOutput("rst_hwdata", bus.ahb_hwdata, 64'h0);
    checkOutput("rst_hprot", bus.ahb_hprot, 4'b0011);
    checkOutput("rst_bvalid", bus.axi_bvalid, 1'b0);
    checkOutput("rst_rvalid", bus.axi_rvalid, 1'b0);
    checkOutput("rst_bresp", bus.axi_bresp, 2'b00);
    checkOutput("rst_rdata", bus.axi_rdata, 64'h0);
    checkOutput("rst_awready", bus.axi_awready, 1'b0);
    tick();
    rst = 1'b0;

    // Zero-wait write
    tick();
    applyStimulus(1'b1, 1'b1, 32'h1000_0008, 3'd3, 1'b1, 64'h1122334455667788);
    mid();
    checkOutput("wr_awready", bus.axi_awready, 1'b1);
    checkOutput("wr_wready", bus.axi_wready, 1'b1);
    checkOutput("wr_arready", bus.axi_arready, 1'b0);
    tick();
    applyStimulus(1'b1, 1'b0, 32'h0, 3'd0, 1'b0, 64'h0);
    mid();
    checkOutput("wr_htrans", bus.ahb_htrans, 2'b10);
    checkOutput("wr_haddr", bus.ahb_haddr, 32'h1000_0008);
    checkOutput("wr_hsize", bus.ahb_hsize, 3'd3);
    checkOutput("wr_hwrite", bus.ahb_hwrite, 1'b1);
    checkOutput("wr_hprot", bus.ahb_hprot, 4'b0011);
    tick();
    mid();
    checkOutput("wr_data_htrans", bus.ahb_htrans, 2'b00);
    checkOutput("wr_hwdata", bus.ahb_hwdata, 64'h1122334455667788);
    checkOutput("wr_bvalid_c2", bus.axi_bvalid, 1'b0);
    tick();
    bus.axi_bready = 1'b1;
    mid();
    checkOutput("wr_bvalid_c3", bus.axi_bvalid, 1'b1);
    checkOutput("wr_bresp", bus.axi_bresp, 2'b00);
    checkOutput("wr_bid", bus.axi_bid, 1'b1);
    tick();
    bus.axi_bready = 1'b0;
    mid();
    checkOutput("wr_bvalid_done", bus.axi_bvalid, 1'b0);

    // Read with two data-phase wait states
    tick();
    applyStimulus(1'b0, 1'b1, 32'h2000_0004, 3'd2, 1'b0, 64'h0);
    mid();
    checkOutput("rd_arready", bus.axi_arready, 1'b1);
    checkOutput("rd_awready", bus.axi_awready, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 3'd0, 1'b0, 64'h0);
    mid();
    checkOutput("rd_htrans", bus.ahb_htrans, 2'b10);
    checkOutput("rd_haddr", bus.ahb_haddr, 32'h2000_0004);
    checkOutput("rd_hsize", bus.ahb_hsize, 3'd2);
    checkOutput("rd_hwrite", bus.ahb_hwrite, 1'b0);
    tick();
    bus.ahb_hready = 1'b0;
    mid();
    checkOutput("rd_data_htrans", bus.ahb_htrans, 2'b00);
    tick();
    mid();
    checkOutput("rd_rvalid_c3", bus.axi_rvalid, 1'b0);
    tick();
    bus.ahb_hready = 1'b1;
    bus.ahb_hrdata = 64'hDEADBEEF;
    mid();
    checkOutput("rd_rvalid_c4", bus.axi_rvalid, 1'b0);
    tick();
    bus.ahb_hrdata = 64'h0;
    bus.axi_rready = 1'b1;
    mid();
    checkOutput("rd_rvalid_c5", bus.axi_rvalid, 1'b1);
    checkOutput("rd_rdata", bus.axi_rdata, 64'hDEADBEEF);
    checkOutput("rd_rresp", bus.axi_rresp, 2'b00);
    checkOutput("rd_rlast", bus.axi_rlast, 1'b1);
    checkOutput("rd_rid", bus.axi_rid, 1'b0);
    tick();
    bus.axi_rready = 1'b0;
    mid();
    checkOutput("rd_rvalid_done", bus.axi_rvalid, 1'b0);

    // AHB two-cycle error response on a write
    tick();
    applyStimulus(1'b1, 1'b1, 32'h0000_0100, 3'd2, 1'b0, 64'hA5);
    mid();
    checkOutput("err_awready", bus.axi_awready, 1'b1);
    tick();
    applyStimulus(1'b1, 1'b0, 32'h0, 3'd0, 1'b0, 64'h0);
    mid();
    checkOutput("err_htrans", bus.ahb_htrans, 2'b10);
    tick();
    bus.ahb_hready = 1'b0;
    bus.ahb_hresp  = 1'b1;
    mid();
    checkOutput("err_bvalid_first", bus.axi_bvalid, 1'b0);
    tick();
    bus.ahb_hready = 1'b1;
    mid();
    checkOutput("err_bvalid_second", bus.axi_bvalid, 1'b0);
    tick();
    bus.ahb_hresp  = 1'b0;
    bus.axi_bready = 1'b1;
    mid();
    checkOutput("err_bvalid", bus.axi_bvalid, 1'b1);
    checkOutput("err_bresp", bus.axi_bresp, 2'b10);
    tick();
    bus.axi_bready = 1'b0;
    applyStimulus(1'b0, 1'b1, 32'h0000_0040, 3'd3, 1'b0, 64'h0);
    mid();
    checkOutput("err_idle_bvalid", bus.axi_bvalid, 1'b0);
    checkOutput("err_idle_arready", bus.axi_arready, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 3'd0, 1'b0, 64'h0);
    bus.axi_rready = 1'b1;
    repeat (3) tick();
    mid();
    checkOutput("err_drain_rvalid", bus.axi_rvalid, 1'b0);
    tick();
    bus.axi_rready = 1'b0;

    // Contention: the last served command was a read, so a write wins first
    applyStimulus(1'b1, 1'b1, 32'h0000_0200, 3'd3, 1'b1, 64'h1);
    applyStimulus(1'b0, 1'b1, 32'h0000_0300, 3'd3, 1'b0, 64'h0);
    bus.axi_bready = 1'b1;
    bus.ahb_hrdata = 64'h77;
    n_acc    = 0;
    hold_cnt = 0;
    for (int cyc = 0; cyc < 80 && n_acc < 4; cyc++) begin
      mid();
      if (bus.axi_awready) begin
        order[n_acc] = 8'h57;
        n_acc++;
      end else if (bus.axi_arready) begin
        order[n_acc] = 8'h52;
        n_acc++;
      end
      if (bus.axi_rvalid && !bus.axi_rready) begin
        hold_cnt++;
        checkOutput("hold_awready", bus.axi_awready, 1'b0);
      end
      tick();
      if (hold_cnt >= 3) bus.axi_rready = 1'b1;
    end
    applyStimulus(1'b1, 1'b0, 32'h0, 3'd0, 1'b0, 64'h0);
    applyStimulus(1'b0, 1'b0, 32'h0, 3'd0, 1'b0, 64'h0);
    bus.axi_rready = 1'b1;
    repeat (6) tick();
    checkOutput("arb_count", n_acc, 4);
    checkOutput("hold_cycles", hold_cnt, 3);
    exp_order = "WRWR";
    for (int i = 0; i < 4; i++) begin
      if (i < n_acc) checkOutput($sformatf("arb_order%0d", i), order[i], exp_order[i]);
    end
    bus.axi_bready = 1'b0;
    bus.axi_rready = 1'b0;

    // Misaligned halfword read
    tick();
    applyStimulus(1'b0, 1'b1, 32'h0000_0003, 3'd1, 1'b1, 64'h0);
    mid();
    checkOutput("mis_arready", bus.axi_arready, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 3'd0, 1'b0, 64'h0);
    bus.axi_rready = 1'b1;
    mid();
`ifdef AXI4_TO_AHB_ALIGN_CHK_EN
    checkOutput("mis_htrans", bus.ahb_htrans, 2'b00);
    checkOutput("mis_rvalid", bus.axi_rvalid, 1'b1);
    checkOutput("mis_rresp", bus.axi_rresp, 2'b10);
    checkOutput("mis_rdata", bus.axi_rdata, 64'h0);
    checkOutput("mis_rid", bus.axi_rid, 1'b1);
`else
    checkOutput("mis_htrans", bus.ahb_htrans, 2'b10);
    checkOutput("mis_haddr", bus.ahb_haddr, 32'h0000_0003);
    checkOutput("mis_hsize", bus.ahb_hsize, 3'd1);
    tick();
    tick();
    mid();
    checkOutput("mis_rvalid", bus.axi_rvalid, 1'b1);
    checkOutput("mis_rresp", bus.axi_rresp, 2'b00);
`endif
    tick();
    bus.axi_rready = 1'b0;
    mid();
    checkOutput("mis_done_rvalid", bus.axi_rvalid, 1'b0);

    // Reset while the write sits in its data phase
    tick();
    applyStimulus(1'b1, 1'b1, 32'h0000_0500, 3'd3, 1'b0, 64'hCAFE);
    mid();
    checkOutput("rst_wr_awready", bus.axi_awready, 1'b1);
    tick();
    applyStimulus(1'b1, 1'b0, 32'h0, 3'd0, 1'b0, 64'h0);
    mid();
    checkOutput("rst_wr_htrans", bus.ahb_htrans, 2'b10);
    tick();
    bus.ahb_hready = 1'b0;
    rst = 1'b1;
    mid();
    tick();
    rst = 1'b0;
    bus.ahb_hready = 1'b1;
    bus.ahb_hrdata = 64'h55;
    applyStimulus(1'b0, 1'b1, 32'h0000_0040, 3'd3, 1'b1, 64'h0);
    mid();
    checkOutput("mrst_htrans", bus.ahb_htrans, 2'b00);
    checkOutput("mrst_bvalid", bus.axi_bvalid, 1'b0);
    checkOutput("mrst_rvalid", bus.axi_rvalid, 1'b0);
    checkOutput("mrst_arready", bus.axi_arready, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 3'd0, 1'b0, 64'h0);
    bus.axi_rready = 1'b1;
    mid();
    checkOutput("mrst_rd_htrans", bus.ahb_htrans, 2'b10);
    checkOutput("mrst_rd_hwrite", bus.ahb_hwrite, 1'b0);
    tick();
    mid();
    tick();
    mid();
    checkOutput("mrst_rd_rvalid", bus.axi_rvalid, 1'b1);
    checkOutput("mrst_rd_rdata", bus.axi_rdata, 64'h55);
    checkOutput("mrst_rd_rresp", bus.axi_rresp, 2'b00);
    tick();
    bus.axi_rready = 1'b0;
    mid();
    checkOutput("mrst_rd_done", bus.axi_rvalid, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
